sram_data_responder: RTL
========================

Name: sram_data_responder

Overview:
- Memory-side responder for the pipeline's MEM stage.
- Accepts 32-bit word read/write requests (the MEM_CMD read/write enables, ALU result as address, src2 value as write data).
- Serves each request as two 16-bit accesses to the external SRAM: low half first, then high half.
- Drives ready low for the whole transaction, so the top level freezes every pipeline register while a transaction is in progress.

Parameters:
WAIT_CYCLES, 1, extra cycles each half-word phase is held; legal range >= 1
ADDR_BASE, 1024, byte address mapped to SRAM word 0
SRAM_AW, 18, SRAM address width (half-word granularity)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
rd_en  in  1  MEM stage read request
wr_en  in  1  MEM stage write request
address  in  32  byte address from ALU result
write_data  in  32  store data (src2 value)
read_data  out  32  assembled load data
ready  out  1  1 = no transaction pending; pipeline may advance
sram_addr  out  SRAM_AW  SRAM half-word address
sram_dq_out  out  16  write data to SRAM (tristate is resolved in the top level)
sram_dq_in  in  16  read data from SRAM
sram_dq_oe  out  1  1 = top level drives sram_dq_out onto the bus
sram_we_n  out  1  SRAM write strobe, active low
sram_oe_n  out  1  SRAM output enable, active low
sram_ce_n  out  1  chip enable, tied active (0)
sram_ub_n  out  1  upper byte enable, tied active (0)
sram_lb_n  out  1  lower byte enable, tied active (0)

Behaviour:
- Phase length P = WAIT_CYCLES+1. One cycle counter, counting 0..P-1.
- FSM states: IDLE, LO, HI, DONE.
- IDLE
  - With rd_en|wr_en = 1: latch op, address and write_data; go to LO.
  - If both rd_en and wr_en are 1: write wins; the request is treated as a write.
- LO: P cycles, then HI.
- HI: P cycles, then DONE.
- DONE: 1 cycle, then IDLE.
- ready (combinational):
  - IDLE: !(rd_en|wr_en), so the requesting cycle already freezes the pipeline.
  - LO and HI: 0.
  - DONE: 1.
  - Total freeze per access = 2P+1 cycles; ready rises in the (2P+2)th cycle after the request appears.
- Address map (from latched address):
  - word = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits; wraps silently, no error.
  - sram_addr = {word,0} in LO and {word,1} in HI. Held at last value in IDLE/DONE.
- Read transaction:
  - sram_oe_n = 0 in LO/HI; sram_dq_oe = 0.
  - sram_dq_in is sampled on the last cycle of LO into read_data[15:0] and on the last cycle of HI into read_data[31:16].
  - read_data is stable from DONE until the next read completes; writes never change it.
- Write transaction:
  - sram_dq_oe = 1 in LO/HI.
  - sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
  - sram_we_n = 0 for counter < P-1, 1 on the last phase cycle (data hold); sram_oe_n = 1.
- Request changes after acceptance are ignored; the latched values complete the transaction.
- Reset (asynchronous, may occur mid-transaction):
  - State -> IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0 immediately.
  - The aborted write may leave one half-word partially written; this is accepted.
- All SRAM control outputs are registered, except ce/ub/lb, which are constant 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/LO/HI/DONE);
  - ADDR_BASE default 1024;
  - the MEM_CMD bit assignments (bit 0 write, bit 1 read) used to derive rd_en/wr_en at the top level.
- No RTL sub-module.
- Bench-only sub-module sram_model: 2^SRAM_AW x 16 array, asynchronous read, write on the rising edge of we_n.

Test Plan:
- Write then read, WAIT_CYCLES=1:
  - wr_en, address=1024, data=0xDEADBEEF -> ready low 5 cycles; sram_addr 0 then 1; model[0]=0xBEEF, model[1]=0xDEAD.
  - rd_en at 1024 -> read_data=0xDEADBEEF in DONE; ready high in 6th cycle.
- Address map: write 0x12345678 at 1028 -> model[2]=0x5678, model[3]=0x1234; model[0] and model[1] unchanged.
- Back-to-back: rd_en held across two consecutive accepted reads (1024, then 1028) -> two separate 5-cycle freezes; read_data updates once per DONE; no request dropped.
- Simultaneous rd_en and wr_en at 1032, data 0xA5A5_5A5A -> treated as a write; sram_oe_n stays 1; read_data unchanged.
- Reset during HI of a write -> sram_we_n=1 and sram_dq_oe=0 in the same cycle; state IDLE; ready=1 while rd_en=wr_en=0.
- WAIT_CYCLES=3 read -> ready low 9 cycles; sram_dq_in sampled only on the 4th cycle of each phase (glitch injected on cycles 1-3 is ignored).

Source files
------------

// File: rtl/sram_data_responder_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: FSM encoding,
// default address base and MEM_CMD bit positions.
package sram_data_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ADDR_BASE_DEFAULT = 1024;

    // MEM_CMD field layout used by the top level to derive rd_en/wr_en
    localparam int MEM_CMD_WR_BIT = 0;
    localparam int MEM_CMD_RD_BIT = 1;

    function automatic logic cmd_is_write(input logic [1:0] cmd);
        return cmd[MEM_CMD_WR_BIT];
    endfunction

    function automatic logic cmd_is_read(input logic [1:0] cmd);
        return cmd[MEM_CMD_RD_BIT];
    endfunction

endpackage

// File: rtl/sram_data_responder.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM accesses
// (low half, then high half) and holds ready low until it completes.
//
// state | meaning
// IDLE  | waiting; a request is latched and the pipeline frozen
// LO    | low half-word phase, P cycles
// HI    | high half-word phase, P cycles
// DONE  | result valid, ready high for one cycle
module sram_data_responder
    import sram_data_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int P  = WAIT_CYCLES + 1;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          op_wr, op_nxt;
    logic [31:0]   addr_q, addr_nxt;
    logic [31:0]   wdata_q, wdata_nxt;
    logic [31:0]   rdata_nxt;
    logic [SRAM_AW-2:0] word;
    logic          in_phase, half;
    logic [SRAM_AW-1:0] sram_addr_nxt;
    logic [15:0]   dq_out_nxt;
    logic          dq_oe_nxt, we_n_nxt, oe_n_nxt;

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_wr;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = read_data;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rd_en | wr_en) begin
                    state_nxt = ST_LO;
                    op_nxt    = wr_en;
                    addr_nxt  = address;
                    wdata_nxt = write_data;
                end
            end
            ST_LO, ST_HI: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (state == ST_LO) begin
                        state_nxt = ST_HI;
                        if (!op_wr) rdata_nxt[15:0] = sram_dq_in;
                    end else begin
                        state_nxt = ST_DONE;
                        if (!op_wr) rdata_nxt[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // SRAM pins are registered, so they are decoded from the next state
    always_comb begin
        word          = (SRAM_AW-1)'((addr_nxt - 32'(ADDR_BASE)) >> 2);
        in_phase      = (state_nxt == ST_LO) || (state_nxt == ST_HI);
        half          = (state_nxt == ST_HI);
        sram_addr_nxt = sram_addr;
        dq_out_nxt    = sram_dq_out;
        if (in_phase) begin
            sram_addr_nxt = {word, half};
            dq_out_nxt    = half ? wdata_nxt[31:16] : wdata_nxt[15:0];
        end
        dq_oe_nxt = in_phase & op_nxt;
        we_n_nxt  = !(in_phase & op_nxt & (cnt_nxt != LAST));
        oe_n_nxt  = !(in_phase & !op_nxt);
    end

    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = !(rd_en | wr_en);
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            op_wr       <= op_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            read_data   <= rdata_nxt;
            sram_addr   <= sram_addr_nxt;
            sram_dq_out <= dq_out_nxt;
            sram_dq_oe  <= dq_oe_nxt;
            sram_we_n   <= we_n_nxt;
            sram_oe_n   <= oe_n_nxt;
        end
    end

endmodule
